// File: rtl/ifetch_queue.sv
// Instruction prefetch queue in front of the F-stage register: issues in-order word fetches,
// buffers {instruction, pc} pairs, and discards wrong-path responses after a redirect.
module ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          MAX_OUT  = 2,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(MAX_OUT + 1);
   localparam int SW = ((CW > OW) ? CW : OW) + 1;

   logic [31:0]   r_data [DEPTH];
   logic [31:0]   r_pc   [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [OW-1:0] r_outstanding;
   logic [OW-1:0] r_drop_cnt;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_rsp_pc;

   logic [SW-1:0] w_reserved;
   logic [31:0]   w_redirect_pc;
   logic          w_issue;
   logic          w_rsp_take;
   logic          w_push;
   logic          w_pop;

   // Queue slots plus in-flight requests may never exceed DEPTH, so a response always has room.
   assign w_reserved    = SW'(r_count) + SW'(r_outstanding);
   assign mem_req_valid = rst_n && !redirect_valid
                          && (r_outstanding < OW'(MAX_OUT))
                          && (w_reserved < SW'(DEPTH));
   assign mem_req_addr  = r_fetch_pc;

   assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
   assign w_issue       = mem_req_valid && mem_req_ready;
   assign w_rsp_take    = mem_rsp_valid && (r_outstanding != '0);
   assign w_push        = w_rsp_take && (r_drop_cnt == '0) && !redirect_valid;
   assign w_pop         = inst_valid && inst_ready && !redirect_valid;

   assign inst_valid = (r_count != '0);
   assign inst       = inst_valid ? r_data[r_head] : '0;
   assign inst_pc    = inst_valid ? r_pc[r_head]   : '0;

   // NOTE: payload storage has no reset; every read of it is masked by inst_valid,
   // so stale contents are never visible and the array can map onto plain flops/RAM.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_data[r_tail] <= mem_rsp_data;
         r_pc[r_tail]   <= r_rsp_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
         r_fetch_pc    <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
      end else if (redirect_valid) begin
         // Everything still in flight is wrong-path; count it so its data is thrown away.
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
         r_fetch_pc    <= w_redirect_pc;
         r_rsp_pc      <= w_redirect_pc;
         r_outstanding <= r_outstanding - OW'(w_rsp_take);
         r_drop_cnt    <= r_outstanding - OW'(w_rsp_take);
      end else begin
         if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
         end
         r_outstanding <= r_outstanding + OW'(w_issue) - OW'(w_rsp_take);
         if (w_rsp_take && (r_drop_cnt != '0)) begin
            r_drop_cnt <= r_drop_cnt - OW'(1);
         end
         if (w_push) begin
            r_tail   <= r_tail + PW'(1);
            r_rsp_pc <= r_rsp_pc + 32'd4;
         end
         if (w_pop) begin
            r_head <= r_head + PW'(1);
         end
         if (w_push != w_pop) begin
            r_count <= w_push ? (r_count + CW'(1)) : (r_count - CW'(1));
         end
      end
   end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a latency-programmable memory model plus a scoreboard of
// the PCs the F stage should see, checked on every pop and every accepted fetch.
module tb_ifetch_queue;
   localparam int          DEPTH    = 4;
   localparam int          MAX_OUT  = 2;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   ifetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_data(mem_rsp_data),
      .inst_valid(inst_valid),
      .inst_ready(inst_ready),
      .inst(inst),
      .inst_pc(inst_pc),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc   = 0;
   int          lat   = 1;
   bit          spur  = 1'b0;
   logic [31:0] exp_q[$];
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   logic [31:0] exp_fetch = RESET_PC;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF ^ {a[15:0], a[31:16]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive the memory response, score the DUT's handshakes, advance past the edge.
   task automatic cycle();
      logic [31:0] a;
      if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = mem_word(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end else if (spur) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = 32'hBAD0_BAD0;
      end else begin
         mem_rsp_valid = 1'b0;
         mem_rsp_data  = '0;
      end
      #1;
      if (redirect_valid) begin
         check("req_blocked_on_redirect", 32'(mem_req_valid), 32'd0);
         exp_q.delete();
         exp_fetch = {redirect_pc[31:2], 2'b00};
      end else begin
         if (inst_valid && inst_ready) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               a = exp_q.pop_front();
               check("sb_pc", inst_pc, a);
               check("sb_inst", inst, mem_word(a));
            end
         end
         if (mem_req_valid && mem_req_ready) begin
            check("req_addr", mem_req_addr, exp_fetch);
            exp_q.push_back(exp_fetch);
            pend_addr.push_back(mem_req_addr);
            pend_due.push_back(cyc + lat);
            exp_fetch += 32'd4;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      mem_rsp_valid = 1'b0;
      #1;
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_req_valid", 32'(mem_req_valid), 32'd0);
      check("rst_inst", inst, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      check("rst_req_addr", mem_req_addr, RESET_PC);
      pend_addr.delete();
      pend_due.delete();
      exp_q.delete();
      exp_fetch = RESET_PC;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc++;
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      cycle();
      redirect_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!inst_valid && n < 30) begin
         cycle();
         n++;
      end
      check({tag, "_valid"}, 32'(inst_valid), 32'd1);
   endtask

   initial begin
      mem_req_ready  = 1'b1;
      mem_rsp_valid  = 1'b0;
      mem_rsp_data   = '0;
      inst_ready     = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      #1;

      // Streaming at 1-cycle latency: consecutive PCs from RESET_PC
      apply_reset();
      lat = 1;
      cycle();
      cycle();
      for (int k = 0; k < 4; k++) begin
         check("t1_valid", 32'(inst_valid), 32'd1);
         check("t1_pc", inst_pc, 32'(4 * k));
         cycle();
      end

      // F stalled: queue fills to DEPTH and fetching stops
      inst_ready = 1'b0;
      repeat (10) cycle();
      check("t2_req_stall", 32'(mem_req_valid), 32'd0);
      check("t2_fetch_pc", mem_req_addr, 32'd32);
      check("t2_head", inst_pc, 32'd16);
      inst_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("t2_drain_valid", 32'(inst_valid), 32'd1);
         check("t2_drain_pc", inst_pc, 32'(16 + 4 * k));
         cycle();
      end

      // Latency 3, two requests in flight, redirect (low bits ignored)
      apply_reset();
      lat = 3;
      cycle();
      cycle();
      check("t3_max_out", 32'(mem_req_valid), 32'd0);
      do_redirect(32'h0000_0103);
      wait_valid("t3");
      check("t3_pc", inst_pc, 32'h0000_0100);
      check("t3_inst", inst, mem_word(32'h0000_0100));

      // Redirect coinciding with a response and a pop
      do_redirect(32'h0000_0200);
      check("t4_empty", 32'(inst_valid), 32'd0);
      check("t4_inst_zero", inst, 32'd0);
      check("t4_pc_zero", inst_pc, 32'd0);
      wait_valid("t4");
      check("t4_pc", inst_pc, 32'h0000_0200);

      // Fetch address wrap at the top of the address space
      lat = 1;
      inst_ready = 1'b0;
      do_redirect(32'hFFFF_FFF8);
      repeat (12) cycle();
      check("t5_fetch_wrap", mem_req_addr, 32'd8);
      inst_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("t5_valid", 32'(inst_valid), 32'd1);
         check("t5_pc", inst_pc, 32'hFFFF_FFF8 + 32'(4 * k));
         cycle();
      end

      // Async reset with the queue full, then a stray response with nothing outstanding
      inst_ready = 1'b0;
      repeat (12) cycle();
      check("t6_full_valid", 32'(inst_valid), 32'd1);
      check("t6_full_head", inst_pc, 32'd8);
      check("t6_full_fetch", mem_req_addr, 32'd24);
      apply_reset();
      mem_req_ready = 1'b0;
      spur = 1'b1;
      cycle();
      spur = 1'b0;
      check("t6_spur_ignored", 32'(inst_valid), 32'd0);
      check("t6_spur_req", 32'(mem_req_valid), 32'd1);
      mem_req_ready = 1'b1;
      inst_ready = 1'b1;
      wait_valid("t6");
      check("t6_refetch_pc", inst_pc, RESET_PC);
      repeat (6) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
